bus_responder_mem: RTL and testbench

BUS_RESPONDER_MEM -- requirements
Module: bus_responder_mem

---
 rtl/bus_responder_mem.sv | 189 ++++++++++++++++++
 tb/tb_bus_responder_mem.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_responder_mem.sv
// Single-initiator bus responder: a word RAM with byte enables plus a memory-mapped
// character output port, with a fixed wait-state count before each response.
module bus_responder_mem #(
    parameter int          DEPTH     = 64,
    parameter int          WAIT      = 1,
    parameter logic [31:0] PORT_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] tx_count
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_CYC = 4'(WAIT);
    localparam logic [31:0] RAM_END  = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PORT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  wait_cnt_r;
    logic [31:0] addr_r, wdata_r;
    logic [2:0]  size_r;
    logic        write_r;
    logic [31:0] rdata_r, tx_count_r;
    logic        ready_r, err_r, tx_valid_r;
    logic [7:0]  tx_data_r;

    logic [31:0] cur_addr_s, cur_wdata_s;
    logic [2:0]  cur_size_s;
    logic        cur_write_s;
    logic        is_port_s, port_store_s, err_s, resp_entry_s;
    logic [3:0]  be_s;
    logic [AW-1:0] idx_s;

    logic [31:0] mem_r [DEPTH];

    function automatic logic [3:0] byte_en_f(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'd0:    byte_en_f = 4'b0001 << a;
            3'd1:    byte_en_f = a[1] ? 4'b1100 : 4'b0011;
            3'd2:    byte_en_f = 4'b1111;
            default: byte_en_f = 4'b0000;
        endcase
    endfunction

    // With WAIT=0 the request goes straight from IDLE to RESP, so decode from the live inputs there.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_addr_s  = addr;
            cur_wdata_s = wdata;
            cur_size_s  = size;
            cur_write_s = write;
        end else begin
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
            cur_size_s  = size_r;
            cur_write_s = write_r;
        end
    end

    // Address/size decode; port stores accept any size and never flag an error.
    always_comb begin
        is_port_s    = (cur_addr_s[31:2] == PORT_ADDR[31:2]);
        port_store_s = is_port_s & cur_write_s;
        idx_s        = cur_addr_s[AW+1:2];
        be_s         = byte_en_f(cur_size_s, cur_addr_s[1:0]);
        if (port_store_s) begin
            err_s = 1'b0;
        end else begin
            err_s = (cur_size_s > 3'd2)
                  | ((cur_size_s == 3'd1) & cur_addr_s[0])
                  | ((cur_size_s == 3'd2) & (cur_addr_s[1:0] != 2'd0))
                  | (~is_port_s & (cur_addr_s >= RAM_END));
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    if (WAIT_CYC != 4'd0) begin
                        state_s = ST_WAIT;
                    end else if (port_store_s) begin
                        state_s = ST_PORT;
                    end else begin
                        state_s = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    state_s = port_store_s ? ST_PORT : ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_PORT: begin
                if (tx_valid_r && tx_ready) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_PORT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        resp_entry_s = (state_s == ST_RESP) && ((state_r == ST_IDLE) || (state_r == ST_WAIT));
    end

    // Control, capture, response and output-port registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            size_r     <= 3'd0;
            write_r    <= 1'b0;
            rdata_r    <= 32'd0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
            tx_count_r <= 32'd0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_RESP);
            err_r   <= resp_entry_s & err_s;
            if (state_r == ST_IDLE && valid) begin
                addr_r     <= addr;
                wdata_r    <= wdata;
                size_r     <= size;
                write_r    <= write;
                wait_cnt_r <= WAIT_CYC;
            end else if (state_r == ST_WAIT && wait_cnt_r != 4'd0) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
            if (resp_entry_s && !cur_write_s) begin
                rdata_r <= err_s ? 32'd0 : (is_port_s ? tx_count_r : mem_r[idx_s]);
            end
            if (state_s == ST_PORT && state_r != ST_PORT) begin
                tx_valid_r <= 1'b1;
                tx_data_r  <= cur_wdata_s[{cur_addr_s[1:0], 3'b000} +: 8];
            end else if (state_r == ST_PORT && tx_valid_r && tx_ready) begin
                tx_valid_r <= 1'b0;
                tx_count_r <= tx_count_r + 32'd1;
            end
        end
    end

    // RAM write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (resp_entry_s && cur_write_s && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign rdata    = rdata_r;
    assign ready    = ready_r;
    assign err      = err_r;
    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign tx_count = tx_count_r;

endmodule

// File: tb/tb_bus_responder_mem.sv
// Directed bench for bus_responder_mem (DEPTH=64, WAIT=1, PORT_ADDR=0x1000).
module tb_bus_responder_mem;

    logic        clk = 1'b0;
    logic        rstb, valid, write, tx_ready;
    logic [31:0] addr, wdata;
    logic [2:0]  size;
    logic [31:0] rdata, tx_count;
    logic        ready, err, tx_valid;
    logic [7:0]  tx_data;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    logic        e;
    int          lat, hi;
    logic        got;

    bus_responder_mem #(.DEPTH(64), .WAIT(1), .PORT_ADDR(32'h0000_1000)) dut (
        .clk(clk), .rstb(rstb), .valid(valid), .write(write), .addr(addr),
        .size(size), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; returns response data, error and latency (cycles after capture, -1 on timeout).
    task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                        output logic [31:0] r, output logic er, output int l);
        @(negedge clk);
        valid = 1'b1; write = w; addr = a; size = s; wdata = d;
        @(posedge clk);
        l = -1; r = 32'd0; er = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            valid = 1'b0;
            if (ready) begin
                r = rdata; er = err; l = i;
                break;
            end
        end
        chk("latency", 32'(l), 32'd2);
        @(negedge clk);
        chk("ready_pulse", 32'(ready), 32'd0);
    endtask

    initial begin
        rstb = 1'b0; valid = 1'b0; write = 1'b0; addr = 32'd0; size = 3'd0;
        wdata = 32'd0; tx_ready = 1'b0;
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_count", tx_count, 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        // Word store/load round trip
        xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, e, lat);
        chk("st_err", 32'(e), 32'd0);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, rd, e, lat);
        chk("ld_word", rd, 32'hDEADBEEF);
        chk("ld_err", 32'(e), 32'd0);

        // Byte and half lane merges
        xfer(1'b1, 32'h10, 3'd2, 32'h11223344, rd, e, lat);
        xfer(1'b1, 32'h12, 3'd0, 32'h00AB0000, rd, e, lat);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, rd, e, lat);
        chk("ld_byte_merge", rd, 32'h11AB3344);
        xfer(1'b1, 32'h12, 3'd1, 32'hCAFE0000, rd, e, lat);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, rd, e, lat);
        chk("ld_half_merge", rd, 32'hCAFE3344);

        // rdata holds while ready is low, then port load returns tx_count=0
        @(negedge clk);
        valid = 1'b1; write = 1'b0; addr = 32'h1000; size = 3'd2;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("hold_ready", 32'(ready), 32'd0);
        chk("hold_rdata", rdata, 32'hCAFE3344);
        @(negedge clk);
        chk("pld0_ready", 32'(ready), 32'd1);
        chk("pld0_rdata", rdata, 32'd0);
        chk("pld0_err", 32'(err), 32'd0);

        // Top RAM word and error cases
        xfer(1'b1, 32'hFC, 3'd2, 32'h13579BDF, rd, e, lat);
        xfer(1'b0, 32'hFC, 3'd2, 32'd0, rd, e, lat);
        chk("ld_top", rd, 32'h13579BDF);
        xfer(1'b1, 32'h0, 3'd2, 32'h0BADF00D, rd, e, lat);
        xfer(1'b0, 32'h102, 3'd2, 32'd0, rd, e, lat);
        chk("e_mis_err", 32'(e), 32'd1);
        chk("e_mis_rdata", rd, 32'd0);
        xfer(1'b0, 32'h10, 3'd3, 32'd0, rd, e, lat);
        chk("e_size_err", 32'(e), 32'd1);
        chk("e_size_rdata", rd, 32'd0);
        xfer(1'b0, 32'h100, 3'd2, 32'd0, rd, e, lat);
        chk("e_range_err", 32'(e), 32'd1);
        chk("e_range_rdata", rd, 32'd0);
        xfer(1'b1, 32'h100, 3'd2, 32'hFFFFFFFF, rd, e, lat);
        chk("e_st_range", 32'(e), 32'd1);
        xfer(1'b1, 32'h10, 3'd3, 32'hFFFFFFFF, rd, e, lat);
        chk("e_st_size", 32'(e), 32'd1);
        xfer(1'b1, 32'h11, 3'd1, 32'hFFFFFFFF, rd, e, lat);
        chk("e_st_half", 32'(e), 32'd1);
        xfer(1'b0, 32'h0, 3'd2, 32'd0, rd, e, lat);
        chk("ram0_unchanged", rd, 32'h0BADF00D);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, rd, e, lat);
        chk("ram10_unchanged", rd, 32'hCAFE3344);

        // Port store with tx_ready held low for 5 cycles of tx_valid
        tx_ready = 1'b0;
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 32'h1000; size = 3'd0; wdata = 32'h00000048;
        @(posedge clk);
        hi = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            valid = 1'b0;
            if (ready) begin
                got = 1'b1;
                break;
            end
            if (tx_valid) begin
                hi++;
                chk("tx_data", 32'(tx_data), 32'h48);
                if (hi == 6) tx_ready = 1'b1;
            end
        end
        chk("port_resp", 32'(got), 32'd1);
        chk("tx_valid_cycles", 32'(hi), 32'd6);
        chk("tx_valid_dropped", 32'(tx_valid), 32'd0);
        chk("port_st_err", 32'(err), 32'd0);
        chk("tx_count1", tx_count, 32'd1);
        tx_ready = 1'b0;
        xfer(1'b0, 32'h1000, 3'd2, 32'd0, rd, e, lat);
        chk("pld1_rdata", rd, 32'd1);
        chk("pld1_err", 32'(e), 32'd0);

        // Reset during PORT aborts the byte
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 32'h1003; size = 3'd0; wdata = 32'h21000000;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("pend_tx_valid", 32'(tx_valid), 32'd1);
        chk("pend_tx_data", 32'(tx_data), 32'h21);
        rstb = 1'b0;
        #1;
        chk("rstp_tx_valid", 32'(tx_valid), 32'd0);
        chk("rstp_tx_count", tx_count, 32'd0);
        chk("rstp_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        xfer(1'b0, 32'h10, 3'd2, 32'd0, rd, e, lat);
        chk("post_rst_ld", rd, 32'hCAFE3344);
        xfer(1'b0, 32'h1000, 3'd2, 32'd0, rd, e, lat);
        chk("post_rst_cnt", rd, 32'd0);

        // Reset during WAIT drops the pending RAM store
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 32'h10; size = 3'd2; wdata = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        rstb = 1'b0;
        #1;
        chk("rstw_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        xfer(1'b0, 32'h10, 3'd2, 32'd0, rd, e, lat);
        chk("rstw_ram", rd, 32'hCAFE3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
